// File: rtl/dispense_sequencer.sv
// dispense_sequencer: timed ingredient sequencer for the coffee machine.
// After a paid order is accepted, it drives one valve at a time from a fixed
// recipe table, pulses bebidaLista when the drink is done and exports the phase
// code for the hex display.
// Optional build macro: SEQ_PURGE_EN adds a PURGA rinse phase (agua on for
// PURGE_TICKS ticks) between the last ingredient and LISTO.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | waiting for start, valves closed
// S_AGUA   | water valve open
// S_CAFE   | coffee valve open
// S_LECHE  | milk valve open
// S_CHOCO  | chocolate valve open
// S_AZUCAR | sugar valve open
// S_PURGA  | line rinse with water (SEQ_PURGE_EN builds only)
// S_LISTO  | single completion cycle, bebidaLista pulses
module dispense_sequencer #(
    parameter int TICK_DIV    = 50000000,
    parameter int PURGE_TICKS = 2
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] bebida,
    input  logic       con_azucar,
    input  logic       abort,
    output logic       busy,
    output logic       agua,
    output logic       cafe,
    output logic       leche,
    output logic       choco,
    output logic       azucar,
    output logic       bebidaLista,
    output logic       err,
    output logic [2:0] fase
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AGUA   = 3'd1,
        S_CAFE   = 3'd2,
        S_LECHE  = 3'd3,
        S_CHOCO  = 3'd4,
        S_AZUCAR = 3'd5,
        S_PURGA  = 3'd6,
        S_LISTO  = 3'd7
    } state_t;

    state_t        r_state;
    logic [2:0]    r_code;
    logic          r_azu;
    logic [CW-1:0] r_cyc;
    logic [7:0]    r_tick;
    logic          r_busy, r_agua, r_cafe, r_leche, r_choco, r_azucar, r_lista, r_err;
    logic [2:0]    r_fase;

    state_t        w_nxt;
    logic          w_err;
    logic          w_accept;
    logic          w_phase_end;

    // Recipe table: phase length in ticks for a given drink code and sugar flag.
    function automatic logic [7:0] phase_ticks(input state_t ph, input logic [2:0] code,
                                               input logic azu);
        logic [7:0] d;
        d = 8'd0;
        case (ph)
            S_AGUA:   d = (code == 3'd2) ? 8'd3 : 8'd2;
            S_CAFE:   case (code)
                          3'd0:    d = 8'd3;
                          3'd2:    d = 8'd6;
                          default: d = 8'd2;
                      endcase
            S_LECHE:  case (code)
                          3'd1:    d = 8'd4;
                          3'd3:    d = 8'd3;
                          default: d = 8'd0;
                      endcase
            S_CHOCO:  d = (code == 3'd3) ? 8'd2 : 8'd0;
            S_AZUCAR: d = azu ? 8'd1 : 8'd0;
            S_PURGA:  d = 8'(PURGE_TICKS);
            default:  d = 8'd0;
        endcase
        return d;
    endfunction

    // First phase after cur with a nonzero length; zero-length phases are skipped.
    function automatic state_t next_phase(input state_t cur, input logic [2:0] code,
                                          input logic azu);
        state_t nxt;
        nxt = S_LISTO;
`ifdef SEQ_PURGE_EN
        if (cur != S_PURGA && PURGE_TICKS > 0)
            nxt = S_PURGA;
`endif
        for (int i = 5; i >= 1; i--) begin
            if (i > int'(cur) && phase_ticks(state_t'(3'(i)), code, azu) != 8'd0)
                nxt = state_t'(3'(i));
        end
        return nxt;
    endfunction

    // Next-state logic: accept/reject orders, honour abort, advance on phase end.
    always_comb begin
        w_nxt       = r_state;
        w_err       = 1'b0;
        w_accept    = 1'b0;
        w_phase_end = (r_cyc == CYC_LAST) &&
                      (r_tick == (phase_ticks(r_state, r_code, r_azu) - 8'd1));
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (bebida <= 3'd3) begin
                        w_accept = 1'b1;
                        w_nxt    = next_phase(S_IDLE, bebida, con_azucar);
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_LISTO: w_nxt = S_IDLE;
            default: begin
                if (abort) begin
                    w_nxt = S_IDLE;
                    w_err = 1'b1;
                end else if (w_phase_end) begin
                    w_nxt = next_phase(r_state, r_code, r_azu);
                end
            end
        endcase
    end

    // State register and order latch.
    always_ff @(posedge clk_50Mhz) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_code  <= 3'd0;
            r_azu   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_accept) begin
                r_code <= bebida;
                r_azu  <= con_azucar;
            end
        end
    end

    // Cycle and tick counters; both restart on every phase change.
    always_ff @(posedge clk_50Mhz) begin
        if (!rst || w_nxt != r_state) begin
            r_cyc  <= '0;
            r_tick <= 8'd0;
        end else if (r_state != S_IDLE) begin
            if (r_cyc == CYC_LAST) begin
                r_cyc  <= '0;
                r_tick <= r_tick + 8'd1;
            end else begin
                r_cyc <= r_cyc + CW'(1);
            end
        end
    end

    // Registered outputs decoded from the next state so valves change cleanly on the edge.
    always_ff @(posedge clk_50Mhz) begin
        if (!rst) begin
            r_busy   <= 1'b0;
            r_agua   <= 1'b0;
            r_cafe   <= 1'b0;
            r_leche  <= 1'b0;
            r_choco  <= 1'b0;
            r_azucar <= 1'b0;
            r_lista  <= 1'b0;
            r_err    <= 1'b0;
            r_fase   <= 3'd0;
        end else begin
            r_busy   <= (w_nxt != S_IDLE);
            r_agua   <= (w_nxt == S_AGUA) || (w_nxt == S_PURGA);
            r_cafe   <= (w_nxt == S_CAFE);
            r_leche  <= (w_nxt == S_LECHE);
            r_choco  <= (w_nxt == S_CHOCO);
            r_azucar <= (w_nxt == S_AZUCAR);
            r_lista  <= (w_nxt == S_LISTO);
            r_err    <= w_err;
            r_fase   <= w_nxt;
        end
    end

    assign busy        = r_busy;
    assign agua        = r_agua;
    assign cafe        = r_cafe;
    assign leche       = r_leche;
    assign choco       = r_choco;
    assign azucar      = r_azucar;
    assign bebidaLista = r_lista;
    assign err         = r_err;
    assign fase        = r_fase;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer with TICK_DIV=4, purge disabled.
// Recipe table rows carry hand-computed phase lengths in cycles; the run
// loop compares the full output word every cycle.
module tb_dispense_sequencer;

    logic       clk_50Mhz = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] bebida = 3'd0;
    logic       con_azucar = 1'b0;
    logic       abort = 1'b0;
    logic       busy, agua, cafe, leche, choco, azucar, bebidaLista, err;
    logic [2:0] fase;

    int n_vec = 0;
    int n_bad = 0;

    dispense_sequencer #(.TICK_DIV(4), .PURGE_TICKS(2)) dut (
        .clk_50Mhz  (clk_50Mhz),
        .rst        (rst),
        .start      (start),
        .bebida     (bebida),
        .con_azucar (con_azucar),
        .abort      (abort),
        .busy       (busy),
        .agua       (agua),
        .cafe       (cafe),
        .leche      (leche),
        .choco      (choco),
        .azucar     (azucar),
        .bebidaLista(bebidaLista),
        .err        (err),
        .fase       (fase)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    // bebida, sugar, cycles in AGUA/CAFE/LECHE/CHOCO/AZUCAR, LISTO cycle (0 = invalid code)
    typedef struct {
        logic [2:0] bebida;
        logic       azu;
        int         d1, d2, d3, d4, d5;
        int         done;
    } rec_t;

    rec_t tbl[9];

    // word layout: busy agua cafe leche choco azucar lista err fase[2:0]
    localparam logic [10:0] W_IDLE = 11'h000;
    localparam logic [10:0] W_ERR  = 11'h008;

    function automatic logic [10:0] sample();
        return {busy, agua, cafe, leche, choco, azucar, bebidaLista, err, fase};
    endfunction

    function automatic logic [10:0] exp_out(input rec_t r, input int c);
        int d[5];
        int cum;
        logic [2:0] f;
        logic lista;
        if (r.done == 0)
            return (c == 1) ? W_ERR : W_IDLE;
        d = '{r.d1, r.d2, r.d3, r.d4, r.d5};
        cum = 0;
        f = 3'd0;
        for (int p = 0; p < 5; p++) begin
            if (c > cum && c <= cum + d[p])
                f = 3'(p + 1);
            cum += d[p];
        end
        lista = (c == r.done);
        if (lista)
            f = 3'd7;
        return {f != 3'd0, f == 3'd1, f == 3'd2, f == 3'd3, f == 3'd4, f == 3'd5,
                lista, 1'b0, f};
    endfunction

    task automatic check(input string name, input int c, input logic [10:0] got,
                         input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_50Mhz);
        #1;
    endtask

    // Start order idx in the current cycle and check every cycle through the idle
    // cycle after LISTO. inj_cyc>0 fires a start(mocaccino) in that busy cycle;
    // abort_listo raises abort during the LISTO cycle.
    task automatic run_rec(input int idx, input int inj_cyc, input bit abort_listo);
        rec_t r;
        int last;
        r = tbl[idx];
        last = (r.done == 0) ? 3 : r.done + 1;
        start = 1'b1;
        bebida = r.bebida;
        con_azucar = r.azu;
        next_cycle();
        start = 1'b0;
        bebida = 3'd6;
        con_azucar = ~r.azu;
        for (int c = 1; c <= last; c++) begin
            check($sformatf("rec%0d", idx), c, sample(), exp_out(r, c));
            if (c == inj_cyc) begin
                start = 1'b1;
                bebida = 3'd3;
                con_azucar = 1'b1;
            end
            if (abort_listo && c == r.done)
                abort = 1'b1;
            next_cycle();
            start = 1'b0;
            abort = 1'b0;
            bebida = 3'd6;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{3'd0, 1'b0,  8, 12,  0, 0, 0, 21};
        tbl[1] = '{3'd3, 1'b1,  8,  8, 12, 8, 4, 41};
        tbl[2] = '{3'd1, 1'b1,  8,  8, 16, 0, 4, 37};
        tbl[3] = '{3'd2, 1'b0, 12, 24,  0, 0, 0, 37};
        tbl[4] = '{3'd0, 1'b1,  8, 12,  0, 0, 4, 25};
        tbl[5] = '{3'd5, 1'b0,  0,  0,  0, 0, 0,  0};
        tbl[6] = '{3'd4, 1'b1,  0,  0,  0, 0, 0,  0};
        tbl[7] = '{3'd7, 1'b0,  0,  0,  0, 0, 0,  0};
        tbl[8] = '{3'd1, 1'b0,  8,  8, 16, 0, 0, 33};

        repeat (3) @(posedge clk_50Mhz);
        #1;
        check("reset", 0, sample(), W_IDLE);
        rst = 1'b1;
        next_cycle();
        check("idle", 0, sample(), W_IDLE);

        for (int i = 0; i < 9; i++)
            run_rec(i, 0, 1'b0);

        // doble with a mocaccino start on cycle 5: ignored, LISTO still at 37
        run_rec(3, 5, 1'b0);

        // abort during LISTO: completion stands, no err afterwards
        run_rec(0, 0, 1'b1);

        // latte, abort on cycle 20 during leche
        start = 1'b1;
        bebida = 3'd1;
        con_azucar = 1'b0;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            check("abort_run", c, sample(), exp_out(tbl[8], c));
            if (c == 20)
                abort = 1'b1;
            next_cycle();
        end
        abort = 1'b0;
        check("abort_err", 21, sample(), W_ERR);
        for (int c = 22; c <= 40; c++) begin
            next_cycle();
            check("abort_quiet", c, sample(), W_IDLE);
        end

        // mocaccino, reset on cycle 18, fresh espresso accepted on cycle 20
        start = 1'b1;
        bebida = 3'd3;
        con_azucar = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            check("rst_run", c, sample(), exp_out(tbl[1], c));
            if (c == 18)
                rst = 1'b0;
            next_cycle();
        end
        rst = 1'b1;
        check("rst_mid", 19, sample(), W_IDLE);
        next_cycle();
        check("rst_after", 20, sample(), W_IDLE);
        run_rec(0, 0, 1'b0);

        // abort together with start while idle: order dropped, no err
        start = 1'b1;
        abort = 1'b1;
        bebida = 3'd0;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start", 1, sample(), W_IDLE);
        next_cycle();
        check("abort_start", 2, sample(), W_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Timed ingredient sequencer for the coffee machine.
- Once the payment/selection FSM has accepted a paid order, this block drives the valve outputs (agua, cafe, leche, choco, azucar) phase by phase from a fixed recipe table.
- It raises bebidaLista when the drink is complete and exports the current phase code to the hex display decoder.

Parameters:
- TICK_DIV, 50000000, clk_50Mhz cycles per recipe tick (1 s at 50 MHz); benches use 4.
- PURGE_TICKS, 2, length of the rinse phase in ticks (used only with SEQ_PURGE_EN).

Ports:
- clk_50Mhz  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle order request, sampled only when busy=0.
- bebida  in  3  drink code: 0 espresso, 1 latte, 2 doble, 3 mocaccino, 4-7 invalid.
- con_azucar  in  1  add sugar phase; sampled together with start.
- abort  in  1  cancel the current order.
- busy  out  1  sequence in progress, including the LISTO cycle.
- agua, cafe, leche, choco, azucar  out  1 each  valve enables; at most one high at any time.
- bebidaLista  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on invalid code or abort.
- fase  out  3  current phase: 0 IDLE, 1 AGUA, 2 CAFE, 3 LECHE, 4 CHOCO, 5 AZUCAR, 6 PURGA, 7 LISTO.

Behaviour:
- Outputs are registered. On any rising edge with rst=0: state=IDLE, all outputs 0, tick and phase counters cleared. This applies mid-sequence too, and valves drop on that edge.
- Recipe table, durations in ticks (AGUA, CAFE, LECHE, CHOCO):
  - espresso 2,3,0,0
  - latte 2,2,4,0
  - doble 3,6,0,0
  - mocaccino 2,2,3,2
- AZUCAR lasts 1 tick if con_azucar is set, else 0.
- bebida and con_azucar are latched on accept. Input changes during busy have no effect.
- Accept: edge N with busy=0, start=1, abort=0 and valid code. From edge N+1: busy=1, first nonzero phase active, its valve=1, fase updated.
- Phase order: AGUA→CAFE→LECHE→CHOCO→AZUCAR→(PURGA)→LISTO.
  - Zero-duration phases are skipped in the same transition and never appear on fase.
  - A phase of d ticks holds its valve for exactly d*TICK_DIV cycles.
  - The next phase starts on the following cycle, with no gap cycle and no overlap.
- Counters:
  - Cycle counter width is clog2(TICK_DIV); it wraps TICK_DIV-1→0 and increments the tick counter.
  - The phase ends when the tick count reaches its duration.
  - Both counters clear on every phase change.
- LISTO: exactly 1 cycle with bebidaLista=1, busy=1, fase=7 and all valves 0; the next cycle is IDLE.
- Invalid code (4-7) with start while idle: err=1 on the next cycle only; state stays IDLE; no valve asserts.
- abort:
  - With busy=1 and not in LISTO: on the next edge all valves go 0, err=1 for 1 cycle, state goes to IDLE, and bebidaLista is not asserted.
  - abort during LISTO is ignored.
  - abort with start while idle: abort wins, the order is dropped, and no err is raised.
- start while busy=1 is ignored; it is not queued.

Optional Feature:
- Macro: SEQ_PURGE_EN.
- Defined: after the last ingredient phase, a PURGA phase (fase=6) lasts PURGE_TICKS*TICK_DIV cycles with agua=1 as a line rinse. It is then followed by LISTO. Abort is honoured during PURGA.
- Undefined: no PURGA state exists, fase never reads 6, and the last ingredient goes straight to LISTO.

Test Plan (TICK_DIV=4, SEQ_PURGE_EN undefined):
- Espresso, no sugar, start at edge 0 → agua=1 on cycles 1-8, cafe=1 on cycles 9-20, bebidaLista=1 on cycle 21 only, busy=0 from cycle 22.
- Mocaccino with sugar → agua 1-8, cafe 9-16, leche 17-28, choco 29-36, azucar 37-40, bebidaLista at 41; fase steps 1,2,3,4,5,7.
- bebida=5 with start → err=1 at cycle 1 only; busy, fase and valves stay 0.
- Latte, abort asserted on cycle 20 (during leche) → cycle 21 has all valves 0, err=1, fase=0; bebidaLista never asserts.
- Doble running, start with bebida=3 on cycle 5 → ignored; recipe completes as doble with bebidaLista at cycle 37.
- Mocaccino, rst=0 on cycle 18 → on cycle 19 all outputs are 0 and the block accepts a fresh start on cycle 20.
